// File: rtl/alu_tile_sched.sv
`default_nettype none
// ------------------------------------------------------------------------
// alu_tile_sched: round-robin, credit-limited issue scheduler for one ALU tile
// Rev 1.0
// ------------------------------------------------------------------------
module alu_tile_sched #(
  parameter int NUM_PORTS       = 5,
  parameter int DATA_W          = 64,
  parameter int CTRL_W          = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] req_a,
  input  logic [NUM_PORTS*DATA_W-1:0] req_b,
  input  logic [NUM_PORTS*CTRL_W-1:0] req_ctrl,
  output logic                        alu_valid,
  input  logic                        alu_ready,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [CTRL_W-1:0]           alu_ctrl,
  output logic [TAG_W-1:0]            alu_tag,
  input  logic                        alu_res_valid,
  input  logic [DATA_W-1:0]           alu_res_data,
  input  logic [TAG_W-1:0]            alu_res_tag,
  output logic [NUM_PORTS-1:0]        res_valid,
  output logic [DATA_W-1:0]           res_data,
  output logic [3:0]                  outstanding,
  output logic [1:0]                  err
);

  localparam logic [TAG_W:0]   c_ports_ext = (TAG_W+1)'(NUM_PORTS);
  localparam logic [TAG_W-1:0] c_last_port = TAG_W'(NUM_PORTS-1);
  localparam logic [3:0]       c_max_out   = 4'(MAX_OUTSTANDING);

  logic [NUM_PORTS-1:0] r_hold_valid;
  logic [DATA_W-1:0]    r_hold_a    [NUM_PORTS];
  logic [DATA_W-1:0]    r_hold_b    [NUM_PORTS];
  logic [CTRL_W-1:0]    r_hold_ctrl [NUM_PORTS];
  logic [TAG_W-1:0]     r_rr_ptr;
  logic                 r_alu_valid;
  logic [DATA_W-1:0]    r_alu_a;
  logic [DATA_W-1:0]    r_alu_b;
  logic [CTRL_W-1:0]    r_alu_ctrl;
  logic [TAG_W-1:0]     r_alu_tag;
  logic [NUM_PORTS-1:0] r_res_valid;
  logic [DATA_W-1:0]    r_res_data;
  logic [3:0]           r_outstanding;
  logic [1:0]           r_err;

  logic [TAG_W:0]       w_idx;
  logic                 w_found;
  logic [TAG_W-1:0]     w_winner;
  logic [TAG_W-1:0]     w_next_ptr;
  logic                 w_slot_free;
  logic                 w_credit_ok;
  logic                 w_grant;
  logic                 w_res_ok;
  logic                 w_dec;

  // Search from r_rr_ptr upward, wrapping at NUM_PORTS; first hit wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
      if (w_idx >= c_ports_ext) w_idx = w_idx - c_ports_ext;
      if (!w_found && r_hold_valid[w_idx[TAG_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[TAG_W-1:0];
      end
    end
  end

  assign w_next_ptr  = (w_winner == c_last_port) ? '0 : w_winner + TAG_W'(1);
  assign w_slot_free = ~r_alu_valid | alu_ready;
  assign w_credit_ok = r_outstanding < c_max_out;
  assign w_grant     = w_slot_free & w_found & w_credit_ok;
  assign w_res_ok    = {1'b0, alu_res_tag} < c_ports_ext;
  assign w_dec       = alu_res_valid && (r_outstanding != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_hold_a[i]    <= '0;
        r_hold_b[i]    <= '0;
        r_hold_ctrl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_grant && (w_winner == TAG_W'(i))) begin
          r_hold_valid[i] <= 1'b0;
        end else if (req_valid[i] && !r_hold_valid[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_a[i]     <= req_a[i*DATA_W +: DATA_W];
          r_hold_b[i]     <= req_b[i*DATA_W +: DATA_W];
          r_hold_ctrl[i]  <= req_ctrl[i*CTRL_W +: CTRL_W];
        end
      end
    end
  end

  // Operands stay put when the slot empties; only alu_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_alu_tag   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant) begin
      r_alu_valid <= 1'b1;
      r_alu_a     <= r_hold_a[w_winner];
      r_alu_b     <= r_hold_b[w_winner];
      r_alu_ctrl  <= r_hold_ctrl[w_winner];
      r_alu_tag   <= w_winner;
      r_rr_ptr    <= w_next_ptr;
    end else if (w_slot_free) begin
      r_alu_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_res_valid   <= '0;
      r_res_data    <= '0;
      r_err         <= '0;
    end else begin
      case ({w_grant, w_dec})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      r_res_valid <= (alu_res_valid && w_res_ok) ? (NUM_PORTS'(1) << alu_res_tag) : '0;
      if (alu_res_valid && w_res_ok) r_res_data <= alu_res_data;
      if (alu_res_valid && (r_outstanding == 4'd0)) r_err[0] <= 1'b1;
      if (alu_res_valid && !w_res_ok) r_err[1] <= 1'b1;
    end
  end

  assign req_ready   = ~r_hold_valid;
  assign alu_valid   = r_alu_valid;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_tag     = r_alu_tag;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_tile_sched.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_alu_tile_sched: directed scoreboard bench for alu_tile_sched. Rev 1.0
// ------------------------------------------------------------------------
module tb_alu_tile_sched;

  typedef struct {
    logic [2:0]  tag;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] ctrl;
  } iss_t;

  typedef struct {
    logic [4:0]  vec;
    logic [63:0] data;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   req_valid;
  logic [4:0]   req_ready;
  logic [319:0] req_a;
  logic [319:0] req_b;
  logic [79:0]  req_ctrl;
  logic         alu_valid;
  logic         alu_ready;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [15:0]  alu_ctrl;
  logic [2:0]   alu_tag;
  logic         alu_res_valid;
  logic [63:0]  alu_res_data;
  logic [2:0]   alu_res_tag;
  logic [4:0]   res_valid;
  logic [63:0]  res_data;
  logic [3:0]   outstanding;
  logic [1:0]   err;

  logic         auto_resp;
  logic         a_v, m_v;
  logic [2:0]   a_t, m_t;
  logic [63:0]  a_d, m_d;

  iss_t exp_iss[$];
  res_t exp_res[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign alu_res_valid = auto_resp ? a_v : m_v;
  assign alu_res_tag   = auto_resp ? a_t : m_t;
  assign alu_res_data  = auto_resp ? a_d : m_d;

  alu_tile_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_tag(alu_tag),
    .alu_res_valid(alu_res_valid), .alu_res_data(alu_res_data), .alu_res_tag(alu_res_tag),
    .res_valid(res_valid), .res_data(res_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
    req_valid[p]          = 1'b1;
    req_a[p*64 +: 64]     = a;
    req_b[p*64 +: 64]     = b;
    req_ctrl[p*16 +: 16]  = c;
  endtask

  task automatic push_iss(input int p, input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
    iss_t e;
    e.tag = 3'(p); e.a = a; e.b = b; e.ctrl = c;
    exp_iss.push_back(e);
  endtask

  task automatic push_res(input int tag, input logic [63:0] d);
    res_t e;
    e.vec = 5'b00001 << tag; e.data = d;
    exp_res.push_back(e);
  endtask

  task automatic result(input logic [2:0] tag, input logic [63:0] d);
    m_v = 1'b1; m_t = tag; m_d = d;
    tick();
    m_v = 1'b0;
  endtask

  function automatic logic [63:0] rr_a(input int p); return 64'h100 + 64'(p); endfunction
  function automatic logic [63:0] rr_b(input int p); return 64'(p) * 64'h10; endfunction
  function automatic logic [15:0] rr_c(input int p); return 16'h10 + 16'(p); endfunction

  // All five ports request together; expected grant order starts at 'start'.
  task automatic rr_round(input int start);
    int p;
    for (int i = 0; i < 5; i++) set_req(i, rr_a(i), rr_b(i), rr_c(i));
    for (int k = 0; k < 5; k++) begin
      p = (start + k) % 5;
      push_iss(p, rr_a(p), rr_b(p), rr_c(p));
      push_res(p, rr_a(p) + rr_b(p));
    end
    tick();
    req_valid = '0;
    repeat (10) tick();
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_req_ready"}, 64'(req_ready), 64'h1f);
    chk({tagname, "_alu_valid"}, 64'(alu_valid), 64'h0);
    chk({tagname, "_alu_a"}, alu_a, 64'h0);
    chk({tagname, "_alu_b"}, alu_b, 64'h0);
    chk({tagname, "_alu_ctrl"}, 64'(alu_ctrl), 64'h0);
    chk({tagname, "_alu_tag"}, 64'(alu_tag), 64'h0);
    chk({tagname, "_res_valid"}, 64'(res_valid), 64'h0);
    chk({tagname, "_res_data"}, res_data, 64'h0);
    chk({tagname, "_outstanding"}, 64'(outstanding), 64'h0);
    chk({tagname, "_err"}, 64'(err), 64'h0);
  endtask

  // ALU model: answers each accepted issue one cycle later with a+b.
  initial begin
    logic        p;
    logic [2:0]  t;
    logic [63:0] d;
    a_v = 1'b0; a_t = '0; a_d = '0;
    forever begin
      @(negedge clk);
      p = auto_resp && alu_valid && alu_ready;
      t = alu_tag;
      d = alu_a + alu_b;
      @(posedge clk);
      #1;
      a_v = p; a_t = t; a_d = d;
    end
  end

  // Scoreboard monitor: checks every issue handshake and every result pulse.
  initial begin
    iss_t ei;
    res_t er;
    forever begin
      @(negedge clk);
      if (rst_n && alu_valid && alu_ready) begin
        if (exp_iss.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL issue_unexpected: got tag %0d, required no issue", alu_tag);
        end else begin
          ei = exp_iss.pop_front();
          chk("issue_tag", 64'(alu_tag), 64'(ei.tag));
          chk("issue_a", alu_a, ei.a);
          chk("issue_b", alu_b, ei.b);
          chk("issue_ctrl", 64'(alu_ctrl), 64'(ei.ctrl));
        end
      end
      if (res_valid != 5'b0) begin
        if (exp_res.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL result_unexpected: got res_valid %b, required none", res_valid);
        end else begin
          er = exp_res.pop_front();
          chk("res_valid", 64'(res_valid), 64'(er.vec));
          chk("res_data", res_data, er.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    alu_ready = 1'b1; auto_resp = 1'b0; m_v = 1'b0; m_t = '0; m_d = '0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single request from port 2.
    push_iss(2, 64'd5, 64'd7, 16'h0001);
    set_req(2, 64'd5, 64'd7, 16'h0001);
    tick();
    req_valid = '0;
    chk("single_not_yet_valid", 64'(alu_valid), 64'h0);
    tick();
    chk("single_valid", 64'(alu_valid), 64'h1);
    chk("single_tag", 64'(alu_tag), 64'd2);
    chk("single_outstanding", 64'(outstanding), 64'd1);
    tick();
    chk("single_slot_empty", 64'(alu_valid), 64'h0);
    push_res(2, 64'd12);
    result(3'd2, 64'd12);
    chk("single_res_vec", 64'(res_valid), 64'b00100);
    chk("single_res_data", res_data, 64'd12);
    chk("single_outstanding_back", 64'(outstanding), 64'd0);

    // Round-robin: pointer at 3 after the port-2 grant, then from reset twice.
    auto_resp = 1'b1;
    rr_round(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rr_round(0);
    rr_round(0);
    auto_resp = 1'b0;
    chk("rr_outstanding", 64'(outstanding), 64'd0);

    // Backpressure with port 1 in the slot.
    alu_ready = 1'b0;
    push_iss(1, 64'hAAAA, 64'h5555, 16'h0042);
    push_iss(1, 64'h1111, 64'h2222, 16'h0043);
    set_req(1, 64'hAAAA, 64'h5555, 16'h0042);
    tick();
    req_valid = '0;
    tick();
    chk("bp_valid", 64'(alu_valid), 64'h1);
    chk("bp_ready_back", 64'(req_ready[1]), 64'h1);
    set_req(1, 64'h1111, 64'h2222, 16'h0043);
    tick();
    set_req(1, 64'h9999, 64'h8888, 16'h0044);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_tag", 64'(alu_tag), 64'd1);
      chk("bp_hold_a", alu_a, 64'hAAAA);
      chk("bp_hold_b", alu_b, 64'h5555);
      chk("bp_hold_ctrl", 64'(alu_ctrl), 64'h0042);
      chk("bp_req_ready1", 64'(req_ready[1]), 64'h0);
    end
    req_valid = '0;
    alu_ready = 1'b1;
    tick();
    chk("bp_second_valid", 64'(alu_valid), 64'h1);
    chk("bp_second_a", alu_a, 64'h1111);
    tick();
    chk("bp_drained", 64'(alu_valid), 64'h0);
    chk("bp_outstanding", 64'(outstanding), 64'd2);
    push_res(1, 64'h123);
    result(3'd1, 64'h123);
    push_res(1, 64'h456);
    result(3'd1, 64'h456);
    chk("bp_outstanding_back", 64'(outstanding), 64'd0);

    // Credit limit: pointer at 2, six requests, four credits.
    for (int p = 0; p < 5; p++) set_req(p, 64'h200 + 64'(p), 64'(p), 16'h20 + 16'(p));
    push_iss(2, 64'h202, 64'd2, 16'h22);
    push_iss(3, 64'h203, 64'd3, 16'h23);
    push_iss(4, 64'h204, 64'd4, 16'h24);
    push_iss(0, 64'h200, 64'd0, 16'h20);
    tick();
    req_valid = '0;
    tick();
    set_req(2, 64'h300, 64'h3, 16'h33);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("cr_outstanding_full", 64'(outstanding), 64'd4);
    chk("cr_held_ready", 64'(req_ready), 64'b11001);
    chk("cr_no_issue", 64'(alu_valid), 64'h0);
    push_res(2, 64'hA);
    result(3'd2, 64'hA);
    chk("cr_count_dropped", 64'(outstanding), 64'd3);
    chk("cr_no_same_cycle_grant", 64'(alu_valid), 64'h0);
    push_iss(1, 64'h201, 64'd1, 16'h21);
    tick();
    chk("cr_fifth_valid", 64'(alu_valid), 64'h1);
    chk("cr_fifth_tag", 64'(alu_tag), 64'd1);
    chk("cr_fifth_count", 64'(outstanding), 64'd4);
    push_res(3, 64'hB);
    result(3'd3, 64'hB);
    chk("cr_count_3", 64'(outstanding), 64'd3);
    chk("cr_blocked", 64'(alu_valid), 64'h0);
    push_iss(2, 64'h300, 64'h3, 16'h33);
    push_res(4, 64'hC);
    result(3'd4, 64'hC);
    chk("cr_load_and_result_count", 64'(outstanding), 64'd3);
    chk("cr_sixth_tag", 64'(alu_tag), 64'd2);
    chk("cr_sixth_a", alu_a, 64'h300);

    // Mid-flight reset: three outstanding, two held.
    push_res(0, 64'hD);
    result(3'd0, 64'hD);
    chk("mf_count_2", 64'(outstanding), 64'd2);
    alu_ready = 1'b0;
    for (int p = 0; p < 5; p++) if (p == 0 || p == 3 || p == 4) set_req(p, 64'h400 + 64'(p), 64'(p), 16'h40);
    tick();
    req_valid = '0;
    tick();
    chk("mf_outstanding", 64'(outstanding), 64'd3);
    chk("mf_held_ready", 64'(req_ready), 64'b01110);
    chk("mf_slot_busy", 64'(alu_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    alu_ready = 1'b1;
    repeat (3) tick();
    chk("mf_dropped_valid", 64'(alu_valid), 64'h0);
    chk("mf_dropped_ready", 64'(req_ready), 64'h1f);

    // Error flags: late result after reset, then an out-of-range tag.
    push_res(2, 64'h77);
    result(3'd2, 64'h77);
    chk("err_count0", 64'(err), 64'b01);
    chk("err_count_stays0", 64'(outstanding), 64'd0);
    result(3'd6, 64'h99);
    chk("err_badtag", 64'(err), 64'b11);
    chk("err_badtag_no_pulse", 64'(res_valid), 64'h0);
    repeat (3) tick();
    chk("err_sticky", 64'(err), 64'b11);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", 64'(err), 64'b00);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("sb_issues_left", 64'(exp_iss.size()), 64'd0);
    chk("sb_results_left", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
